// File: rtl/m68k_bus_responder_if.sv
// 68000 bus signals as seen by the responder: raw strobes, address and data in,
// read data plus open-drain enables out.
interface m68k_bus_responder_if;
    logic        nAS;
    logic        nUDS;
    logic        nLDS;
    logic        RnW;
    logic [23:1] A_IN;
    logic [15:0] D_IN;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic        nDTACK_OE;

    modport slave (
        input  nAS, nUDS, nLDS, RnW, A_IN, D_IN,
        output D_OUT, D_OE, nDTACK_OE
    );

    modport master (
        output nAS, nUDS, nLDS, RnW, A_IN, D_IN,
        input  D_OUT, D_OE, nDTACK_OE
    );
endinterface

// File: rtl/m68k_bus_responder.sv
// Passive 68000 bus target: answers cycles in a small address window from a
// byte-lane-writable register file that the Pi host port can also access.
module m68k_bus_responder #(
    parameter logic [23:0] BASE_ADDR   = 24'hE80000,
    parameter int          ADDR_BITS   = 4,
    parameter int          DTACK_DELAY = 2
) (
    input  logic                 sys_clk,
    input  logic                 nRESET,
    m68k_bus_responder_if.slave  bus,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic                 host_wr,
    input  logic [15:0]          host_wdata,
    output logic [15:0]          host_rdata,
    output logic                 bus_hit
);

    localparam int         WORDS      = 2 ** ADDR_BITS;
    localparam logic [3:0] DELAY_LAST = 4'(DTACK_DELAY > 0 ? DTACK_DELAY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        WRITE,
        HOLD,
        IGNORE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rnw_q, rnw_d;
    logic        busHit_q, busHit_d;
    logic [15:0] dOut_q, dOut_d;
    logic [15:0] regFile_q [WORDS];
    logic [15:0] hostRdata_q;

    logic        asMeta_q, asSync_q;
    logic        udsMeta_q, udsSync_q;
    logic        ldsMeta_q, ldsSync_q;
    logic        rnwMeta_q, rnwSync_q;
    logic [23:1] aMeta_q, aSync_q;
    logic [15:0] dMeta_q, dSync_q;

    logic                 asLow;
    logic                 dsLow;
    logic                 hit;
    logic                 takeCycle;
    logic                 commitWr;
    logic [ADDR_BITS-1:0] wordIdx;

    // Strobes reset to their negated level so no cycle is seen straight out of reset.
    always_ff @(posedge sys_clk or negedge nRESET) begin
        if (!nRESET) begin
            asMeta_q  <= 1'b1;
            asSync_q  <= 1'b1;
            udsMeta_q <= 1'b1;
            udsSync_q <= 1'b1;
            ldsMeta_q <= 1'b1;
            ldsSync_q <= 1'b1;
            rnwMeta_q <= 1'b1;
            rnwSync_q <= 1'b1;
            aMeta_q   <= '0;
            aSync_q   <= '0;
            dMeta_q   <= '0;
            dSync_q   <= '0;
        end else begin
            asMeta_q  <= bus.nAS;
            asSync_q  <= asMeta_q;
            udsMeta_q <= bus.nUDS;
            udsSync_q <= udsMeta_q;
            ldsMeta_q <= bus.nLDS;
            ldsSync_q <= ldsMeta_q;
            rnwMeta_q <= bus.RnW;
            rnwSync_q <= rnwMeta_q;
            aMeta_q   <= bus.A_IN;
            aSync_q   <= aMeta_q;
            dMeta_q   <= bus.D_IN;
            dSync_q   <= dMeta_q;
        end
    end

    assign asLow     = !asSync_q;
    assign dsLow     = !udsSync_q || !ldsSync_q;
    assign hit       = (aSync_q[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
    assign wordIdx   = aSync_q[ADDR_BITS:1];
    assign takeCycle = (state_q == DECODE) && asLow && hit && dsLow;
    assign commitWr  = takeCycle && !rnwSync_q;

    always_ff @(posedge sys_clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rnw_q    <= 1'b1;
            busHit_q <= 1'b0;
            dOut_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rnw_q    <= rnw_d;
            busHit_q <= busHit_d;
            dOut_q   <= dOut_d;
        end
    end

    // Read data is captured on entry to READ so later host writes cannot disturb it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rnw_d    = rnw_q;
        busHit_d = 1'b0;
        dOut_d   = dOut_q;
        case (state_q)
            IDLE: begin
                if (asLow) state_d = DECODE;
            end
            DECODE: begin
                if (!asLow) begin
                    state_d = IDLE;
                end else if (!hit) begin
                    state_d = IGNORE;
                end else if (dsLow) begin
                    rnw_d = rnwSync_q;
                    cnt_d = '0;
                    if (rnwSync_q) dOut_d = regFile_q[wordIdx];
                    if (DTACK_DELAY == 0) state_d = HOLD;
                    else                  state_d = rnwSync_q ? READ : WRITE;
                end
            end
            READ, WRITE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == DELAY_LAST) state_d = HOLD;
            end
            HOLD: begin
                if (!asLow) begin
                    state_d  = IDLE;
                    busHit_d = 1'b1;
                end
            end
            IGNORE: begin
                if (!asLow) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The bus write is applied after the host write so it wins on the lanes it strobes.
    always_ff @(posedge sys_clk or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < WORDS; i++) regFile_q[i] <= '0;
            hostRdata_q <= '0;
        end else begin
            hostRdata_q <= regFile_q[host_addr];
            if (host_wr) regFile_q[host_addr] <= host_wdata;
            if (commitWr) begin
                if (!udsSync_q) regFile_q[wordIdx][15:8] <= dSync_q[15:8];
                if (!ldsSync_q) regFile_q[wordIdx][7:0]  <= dSync_q[7:0];
            end
        end
    end

    assign bus.D_OUT     = dOut_q;
    assign bus.D_OE      = (state_q == READ) || ((state_q == HOLD) && rnw_q);
    assign bus.nDTACK_OE = (state_q == HOLD);
    assign host_rdata    = hostRdata_q;
    assign bus_hit       = busHit_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: cycle-exact bus reads/writes, misses,
// host/bus write collision, AS abort and reset in the middle of a read.
module tb_m68k_bus_responder;

    localparam logic [23:0] BASE = 24'hE80000;

    logic        sys_clk = 1'b0;
    logic        nRESET;
    logic [3:0]  host_addr;
    logic        host_wr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        bus_hit;

    int checks = 0;
    int errors = 0;

    m68k_bus_responder_if busIf ();

    m68k_bus_responder #(
        .BASE_ADDR  (BASE),
        .ADDR_BITS  (4),
        .DTACK_DELAY(2)
    ) dut (
        .sys_clk   (sys_clk),
        .nRESET    (nRESET),
        .bus       (busIf),
        .host_addr (host_addr),
        .host_wr   (host_wr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .bus_hit   (bus_hit)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input logic nas, input logic nuds, input logic nlds,
                                 input logic rnw, input logic [23:0] byteAddr,
                                 input logic [15:0] data);
        busIf.nAS  = nas;
        busIf.nUDS = nuds;
        busIf.nLDS = nlds;
        busIf.RnW  = rnw;
        busIf.A_IN = byteAddr[23:1];
        busIf.D_IN = data;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkBus(input string tag, input logic doe, input logic dtack,
                            input logic hitPulse);
        checkOutput({tag, ".D_OE"}, {15'd0, busIf.D_OE}, {15'd0, doe});
        checkOutput({tag, ".nDTACK_OE"}, {15'd0, busIf.nDTACK_OE}, {15'd0, dtack});
        checkOutput({tag, ".bus_hit"}, {15'd0, bus_hit}, {15'd0, hitPulse});
    endtask

    task automatic hostWrite(input logic [3:0] addr, input logic [15:0] data);
        host_addr  = addr;
        host_wdata = data;
        host_wr    = 1'b1;
        tick(1);
        host_wr    = 1'b0;
    endtask

    task automatic hostRead(input logic [3:0] addr, input logic [15:0] expected,
                            input string tag);
        host_addr = addr;
        tick(1);
        checkOutput(tag, host_rdata, expected);
    endtask

    initial begin
        nRESET     = 1'b0;
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        applyStimulus(1, 1, 1, 1, BASE, 16'h0000);
        tick(2);
        checkBus("reset", 0, 0, 0);
        checkOutput("reset.D_OUT", busIf.D_OUT, 16'h0000);
        checkOutput("reset.host_rdata", host_rdata, 16'h0000);
        nRESET = 1'b1;
        tick(2);

        // Read hit on word 3, strobes asserted together with AS.
        hostWrite(4'd3, 16'hBEEF);
        hostRead(4'd3, 16'hBEEF, "preload.word3");
        applyStimulus(0, 0, 0, 1, BASE + 24'd6, 16'h0000);
        tick(3); checkBus("rd.k3", 0, 0, 0);
        tick(1); checkBus("rd.k4", 1, 0, 0);
        checkOutput("rd.D_OUT", busIf.D_OUT, 16'hBEEF);
        tick(1); checkBus("rd.k5", 1, 0, 0);
        tick(1); checkBus("rd.k6", 1, 1, 0);
        tick(1); checkBus("rd.k7", 1, 1, 0);
        applyStimulus(1, 1, 1, 1, BASE + 24'd6, 16'h0000);
        tick(2); checkBus("rdrel.k2", 1, 1, 0);
        tick(1); checkBus("rdrel.k3", 0, 0, 1);
        tick(1); checkBus("rdrel.k4", 0, 0, 0);

        // Lower-byte write to word 0, data strobe arriving after AS.
        hostWrite(4'd0, 16'h1234);
        applyStimulus(0, 1, 1, 0, BASE, 16'hABCD);
        tick(4); checkBus("wr.wait", 0, 0, 0);
        applyStimulus(0, 1, 0, 0, BASE, 16'hABCD);
        tick(3); checkBus("wr.k3", 0, 0, 0);
        tick(1); checkBus("wr.k4", 0, 0, 0);
        tick(1); checkBus("wr.k5", 0, 1, 0);
        applyStimulus(1, 1, 1, 0, BASE, 16'hABCD);
        tick(2); checkBus("wrrel.k2", 0, 1, 0);
        tick(1); checkBus("wrrel.k3", 0, 0, 1);
        hostRead(4'd0, 16'h12CD, "wr.word0");

        // Address just past the window.
        applyStimulus(0, 0, 0, 1, BASE + 24'h20, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            tick(1); checkBus("miss.active", 0, 0, 0);
        end
        applyStimulus(1, 1, 1, 1, BASE + 24'h20, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick(1); checkBus("miss.release", 0, 0, 0);
        end

        // Host full-word write and bus UDS write to word 5 commit on the same edge.
        applyStimulus(0, 1, 1, 0, BASE + 24'hA, 16'h55AA);
        tick(4);
        applyStimulus(0, 0, 1, 0, BASE + 24'hA, 16'h55AA);
        tick(2);
        host_addr  = 4'd5;
        host_wdata = 16'hFFFF;
        host_wr    = 1'b1;
        tick(1);
        host_wr    = 1'b0;
        tick(2); checkBus("col.k5", 0, 1, 0);
        applyStimulus(1, 1, 1, 0, BASE + 24'hA, 16'h55AA);
        tick(3); checkBus("colrel.k3", 0, 0, 1);
        hostRead(4'd5, 16'h55FF, "col.word5");

        // AS without any data strobe, then a normal read proves the FSM is idle.
        applyStimulus(0, 1, 1, 1, BASE + 24'd4, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick(1); checkBus("abort.low", 0, 0, 0);
        end
        applyStimulus(1, 1, 1, 1, BASE + 24'd4, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick(1); checkBus("abort.high", 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 1, BASE + 24'hA, 16'h0000);
        tick(3); checkBus("post.k3", 0, 0, 0);
        tick(1); checkBus("post.k4", 1, 0, 0);
        checkOutput("post.D_OUT", busIf.D_OUT, 16'h55FF);
        tick(2); checkBus("post.k6", 1, 1, 0);
        applyStimulus(1, 1, 1, 1, BASE + 24'hA, 16'h0000);
        tick(3); checkBus("postrel.k3", 0, 0, 1);

        // Reset while holding a read.
        applyStimulus(0, 0, 0, 1, BASE + 24'd6, 16'h0000);
        tick(7); checkBus("rst.hold", 1, 1, 0);
        nRESET = 1'b0;
        #1;
        checkBus("rst.async", 0, 0, 0);
        checkOutput("rst.D_OUT", busIf.D_OUT, 16'h0000);
        applyStimulus(1, 1, 1, 1, BASE, 16'h0000);
        tick(2);
        nRESET = 1'b1;
        tick(2);
        hostRead(4'd3, 16'h0000, "rst.word3");
        hostRead(4'd5, 16'h0000, "rst.word5");

        // First bus cycle after reset: full-word write to word 3.
        applyStimulus(0, 0, 0, 0, BASE + 24'd6, 16'hC0DE);
        tick(5); checkBus("rstwr.k5", 0, 0, 0);
        tick(1); checkBus("rstwr.k6", 0, 1, 0);
        applyStimulus(1, 1, 1, 0, BASE + 24'd6, 16'hC0DE);
        tick(3); checkBus("rstwrrel.k3", 0, 0, 1);
        hostRead(4'd3, 16'hC0DE, "rstwr.word3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m68k_bus_responder.md
# m68k_bus_responder

Passive 68000-bus target for the PiStorm16 gateware: it answers asynchronous 68k bus cycles that hit a small address window by returning data and asserting DTACK, which is the responder end of the bus protocol our Pi-driven initiator generates. It holds a 16-bit-wide register file that the bus reads and writes with byte-lane granularity. A Pi-side host port gives the Pi read/write access to the same file. The block sits beside the bus-master state machine and shares the Amiga bus pads through their `_OE` open-drain controls.

## Interface
- `BASE_ADDR`, default 24'hE80000: window base; must be aligned to the window size.
- `ADDR_BITS`, default 4: log2 of the number of 16-bit words (window = 2^(ADDR_BITS+1) bytes).
- `DTACK_DELAY`, default 2: number of sys_clk cycles from data-bus drive to DTACK assertion (range 0–15).
- Clock and reset: one clock; reset is asynchronous and active-low. Ports `sys_clk` and `nRESET`.
- `sys_clk` in 1: system clock, 140 MHz.
- `nRESET` in 1: asynchronous active-low reset.
- `nAS` in 1: bus address strobe (raw, asynchronous).
- `nUDS` in 1: upper data strobe (raw).
- `nLDS` in 1: lower data strobe (raw).
- `RnW` in 1: 1 = read, 0 = write (raw).
- `A_IN` in 23: bus address [23:1] (raw).
- `D_IN` in 16: bus data (raw).
- `D_OUT` out 16: read data to the bus.
- `D_OE` out 1: drive `D_OUT` onto the data bus.
- `nDTACK_OE` out 1: 1 = pull nDTACK low.
- `host_addr` in ADDR_BITS: Pi-side word address.
- `host_wr` in 1: single-cycle write strobe.
- `host_wdata` in 16: Pi-side write data.
- `host_rdata` out 16: registered read data for `host_addr`, valid one cycle after the address.
- `bus_hit` out 1: single-cycle pulse when a bus cycle completes in the window.

## Operation
- Synchronisation: `nAS`, `nUDS`, `nLDS`, `RnW`, `A_IN` and `D_IN` pass through 2-flop synchronisers (as_s, ds_s, …). All decisions use the synchronised values.
- Decode: hit = `A_s[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]`; word index = `A_s[ADDR_BITS:1]`.
- FSM states:
  - IDLE: when as_s is low, go to DECODE.
  - DECODE:
    - as_s high: return to IDLE.
    - Miss: go to IGNORE.
    - Hit and at least one DS low: latch index, RnW and strobes.
      - Read: go to READ.
      - Write: commit the byte lanes whose DS is low (UDS → [15:8], LDS → [7:0]) from `D_s`, then go to WRITE.
    - Hit with both DS high: stay in DECODE (the 68k asserts read DS with AS, write DS at S4).
  - READ: `D_OUT` = word at the latched index (full 16 bits, independent of strobes), `D_OE` = 1; count DTACK_DELAY cycles, then `nDTACK_OE` = 1 and go to HOLD.
  - WRITE: count DTACK_DELAY cycles, then `nDTACK_OE` = 1 and go to HOLD.
  - HOLD: keep the outputs until as_s is high. Then `D_OE` = 0, `nDTACK_OE` = 0, pulse `bus_hit`, go to IDLE.
  - IGNORE: outputs never asserted; go to IDLE when as_s is high.
- Host port:
  - `host_wr` writes the full word.
  - Same cycle and same word as a bus write commit: the bus write wins for the lanes it writes; the host data lands in the other lanes.
  - A host write during a read in READ/HOLD does not change the `D_OUT` already captured: `D_OUT` is registered on entry to READ.
- Reset:
  - `nRESET` low immediately forces IDLE, `D_OE` = 0, `nDTACK_OE` = 0, `D_OUT` = 0, `bus_hit` = 0, `host_rdata` = 0, and the register file all-zero.
  - A reset mid-cycle abandons the cycle; the bus then sees a missing DTACK.

## Timing
- Raw edge to synchronised value: 2 cycles.
- Let N be the first cycle DECODE sees as_s and ds_s both low with a hit.
  - `D_OE` high from N+1.
  - `nDTACK_OE` high from N+1+DTACK_DELAY.
  - Write data is committed at N+1.
- After as_s goes high, `D_OE`/`nDTACK_OE` drop the next cycle: raw AS negation to release is ≤ 3 cycles (21 ns), which is inside 68k S7.
- Back-to-back cycles: IDLE → DECODE needs one cycle after release; no minimum gap beyond that.

## Test plan
- Read hit: preload word 3 = 16'hBEEF via the host port; bus read at BASE+6 with UDS/LDS low → `D_OUT` = 16'hBEEF with `D_OE` high, `nDTACK_OE` high exactly DTACK_DELAY cycles later; both drop within 3 cycles of nAS high; `bus_hit` pulses once.
- Byte write: word 0 = 16'h1234; bus write of 16'hAB CD at BASE+0 with only LDS low → word 0 = 16'h12CD, readable on `host_rdata`.
- Miss: bus read at BASE + 2^(ADDR_BITS+1) → `D_OE` and `nDTACK_OE` stay 0 for the whole cycle; `bus_hit` stays 0.
- Collision: host write of 16'hFFFF and bus UDS-only write of 16'h55xx to word 5 in the same cycle → word 5 = 16'h55FF.
- Reset mid-read: assert `nRESET` while in HOLD → `D_OE` and `nDTACK_OE` go 0 asynchronously, the register file reads 0, and the next bus cycle completes normally.
- AS aborted before DS: nAS low for 4 cycles with no DS, then high → FSM returns to IDLE, no outputs asserted.
